sec_timer: RTL and testbench
============================

Name: sec_timer

Overview:
- Seconds timekeeper for the seven-segment path: produces the 6-bit value 0..59 on `dig`, which the two-digit segment decoder consumes directly.
- Counts up (stopwatch, wraps 59->0 with a carry pulse) or down (timer, stops at 0 with a done pulse).
- Control inputs are single-cycle pulses from the debounced button stage.

Parameters:
- TICK_DIV, 100000000, clk cycles per count step (1 s at 100 MHz); minimum 2.
- MAX_VAL, 59, highest count value; must fit in 6 bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- nrst  input  1  synchronous reset, active-low
- start_stop  input  1  one-cycle pulse; toggles run/pause
- clr  input  1  one-cycle pulse; count to 0, stop
- load  input  1  one-cycle pulse; preset count from load_val, stop
- load_val  input  6  preset value, sampled on load
- dir  input  1  0 = count up, 1 = count down
- dig  output  6  current count, 0..MAX_VAL, registered
- running  output  1  high while in RUN
- tick  output  1  one-cycle pulse on every count change due to a step
- wrap  output  1  one-cycle pulse when up-count goes MAX_VAL->0
- done  output  1  one-cycle pulse when down-count reaches 0

Behaviour:
- Reset and clock: one clock; reset is synchronous, active-low (nrst sampled on clk rising edge).
- Reset values: state IDLE, dig=0, prescaler=0, running=0, tick=0, wrap=0, done=0.
- States: IDLE (stopped, never run since clr/load), RUN, PAUSE, DONE.
- Priority when inputs coincide in one cycle: nrst > clr > load > start_stop > prescaler step.
- clr: dig<=0, prescaler<=0, state<=IDLE, no tick/wrap/done pulse.
- load: dig<=min(load_val, MAX_VAL), prescaler<=0, state<=IDLE, no pulses.
- start_stop transitions:
  - IDLE->RUN and PAUSE->RUN, each with prescaler<=0.
  - RUN->PAUSE; the prescaler holds its value while paused.
  - In DONE, start_stop is ignored; leave DONE only via clr, load or reset.
- Special case: start_stop in IDLE with dir=1 and dig=0 goes straight to DONE, pulses done, running stays 0.
- Prescaler in RUN:
  - Counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1 it returns to 0 and a step occurs.
  - First step lands TICK_DIV cycles after the start pulse.
- Step, dir=0:
  - dig<dig_max: dig<=dig+1, tick=1.
  - dig==MAX_VAL: dig<=0, tick=1, wrap=1; stays in RUN.
- Step, dir=1:
  - dig>1: dig<=dig-1, tick=1.
  - dig==1: dig<=0, tick=1, done=1, state<=DONE.
- dir is sampled at each step, so a change mid-run takes effect on the next step. The prescaler is not reset by a dir change.
- Pulse timing: tick/wrap/done are registered, asserted exactly one cycle, coincident with the new dig value.
- running is a registered decode of state==RUN.
- dig is never outside 0..MAX_VAL.
- Prescaler width is the minimum that holds TICK_DIV-1 (computed with clog2).

Decomposition:
- Shared constants file holds:
  - state encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE (2 bits);
  - the default TICK_DIV for the 100 MHz board clock;
  - MAX_VAL 59.
- One sub-module is natural: tick_gen (prescaler with enable and sync clear, emits a one-cycle step strobe). It is reusable for the display scan-rate divider.

Test Plan (TICK_DIV=4 unless noted):
- Reset, then start_stop, dir=0 -> first tick 4 cycles after the pulse, dig 0->1; tick every 4 cycles; running=1 throughout.
- load_val=58, load, start_stop, dir=0 -> dig 58,59,0; wrap=1 only on the cycle dig becomes 0; stays RUN; dig=1 next step.
- load_val=2, load, dir=1, start_stop -> dig 2,1,0; done=1 with dig=0; running=0; further start_stop pulses leave dig=0, state DONE.
- RUN, dig=5, prescaler at 2 -> start_stop pauses; 20 idle cycles; start_stop resumes with prescaler cleared; next tick 4 cycles later, dig=6.
- Simultaneous cases:
  - clr, load(30) and start_stop in the same cycle -> dig=0, IDLE, no pulses.
  - load_val=63 -> dig clamps to 59.
- Mid-run reset: nrst low for one cycle at dig=17 -> next cycle dig=0, running=0, all pulses 0. A second scenario uses TICK_DIV=2 for minimum-divider coverage.

Source files
------------

// File: rtl/sec_timer_pkg.sv
// Shared constants and helpers for the seconds timekeeper and its prescaler.
// Imported by sec_timer and sec_timer_tick_gen.
package sec_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Board clock is 100 MHz, so one count step per second.
    localparam int DEF_TICK_DIV = 100_000_000;
    localparam int DEF_MAX_VAL  = 59;
    localparam int DIG_W        = 6;

    function automatic logic [DIG_W-1:0] clamp_dig(input logic [DIG_W-1:0] v,
                                                   input logic [DIG_W-1:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/sec_timer_tick_gen.sv
// Free-running prescaler with enable and synchronous clear.
// Emits a one-cycle step strobe on the cycle it wraps from DIV-1 back to 0.
module sec_timer_tick_gen
    import sec_timer_pkg::*;
#(
    parameter int DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Strobe is combinational so the parent can register it alongside its own update.
    assign step = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= step ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sec_timer.sv
// Seconds timekeeper: stopwatch (up, wraps MAX_VAL->0) or countdown timer (down, stops at 0).
// dig feeds the two-digit segment decoder; tick/wrap/done are one-cycle registered pulses.
module sec_timer
    import sec_timer_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int MAX_VAL  = DEF_MAX_VAL
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start_stop,
    input  logic             clr,
    input  logic             load,
    input  logic [DIG_W-1:0] load_val,
    input  logic             dir,
    output logic [DIG_W-1:0] dig,
    output logic             running,
    output logic             tick,
    output logic             wrap,
    output logic             done
);

    localparam logic [DIG_W-1:0] MAX_DIG = DIG_W'(MAX_VAL);

    state_t           state;
    state_t           state_nx;
    logic [DIG_W-1:0] dig_nx;
    logic             tick_nx;
    logic             wrap_nx;
    logic             done_nx;
    logic             psc_en;
    logic             psc_clr;
    logic             step;

    // The prescaler only advances on cycles where no control pulse overrides the step.
    assign psc_en  = (state == ST_RUN) && !clr && !load && !start_stop;
    assign psc_clr = clr || load ||
                     (start_stop && ((state == ST_IDLE) || (state == ST_PAUSE)));

    sec_timer_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .nrst (nrst),
        .en   (psc_en),
        .clr  (psc_clr),
        .step (step)
    );

    always_comb begin
        state_nx = state;
        dig_nx   = dig;
        tick_nx  = 1'b0;
        wrap_nx  = 1'b0;
        done_nx  = 1'b0;

        if (clr) begin
            state_nx = ST_IDLE;
            dig_nx   = '0;
        end else if (load) begin
            state_nx = ST_IDLE;
            dig_nx   = clamp_dig(load_val, MAX_DIG);
        end else if (start_stop) begin
            case (state)
                ST_IDLE: begin
                    // Countdown from zero has nothing to count: finish immediately.
                    if (dir && (dig == '0)) begin
                        state_nx = ST_DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = ST_RUN;
                    end
                end
                ST_PAUSE: state_nx = ST_RUN;
                ST_RUN:   state_nx = ST_PAUSE;
                default:  state_nx = state;
            endcase
        end else if (step) begin
            if (!dir) begin
                tick_nx = 1'b1;
                if (dig >= MAX_DIG) begin
                    dig_nx  = '0;
                    wrap_nx = 1'b1;
                end else begin
                    dig_nx = dig + DIG_W'(1);
                end
            end else if (dig > DIG_W'(1)) begin
                dig_nx  = dig - DIG_W'(1);
                tick_nx = 1'b1;
            end else if (dig == DIG_W'(1)) begin
                dig_nx   = '0;
                tick_nx  = 1'b1;
                done_nx  = 1'b1;
                state_nx = ST_DONE;
            end else begin
                // Direction flipped to down while sitting at 0: nothing changes, timer ends.
                done_nx  = 1'b1;
                state_nx = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            dig     <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            dig     <= dig_nx;
            running <= (state_nx == ST_RUN);
            tick    <= tick_nx;
            wrap    <= wrap_nx;
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_sec_timer.sv
// Directed bench for sec_timer (TICK_DIV=4 main instance, TICK_DIV=2 second instance).
// Pulse outputs are checked by a monitor against an expected queue tagged with cycle numbers.
module tb_sec_timer;
    import sec_timer_pkg::*;

    localparam int TD = 4;
    localparam int W  = 42;

    logic       clk = 1'b0;
    logic       nrst, start_stop, clr, load, dir;
    logic [5:0] load_val;
    logic [5:0] dig;
    logic       running, tick, wrap, done;

    logic       nrst2, ss2, clr2, load2, dir2;
    logic [5:0] load_val2;
    logic [5:0] dig2;
    logic       running2, tick2, wrap2, done2;

    int unsigned cyc = 0;
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sec_timer #(.TICK_DIV(TD), .MAX_VAL(59)) u_dut (
        .clk(clk), .nrst(nrst), .start_stop(start_stop), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .dig(dig), .running(running),
        .tick(tick), .wrap(wrap), .done(done)
    );

    sec_timer #(.TICK_DIV(2), .MAX_VAL(59)) u_dut2 (
        .clk(clk), .nrst(nrst2), .start_stop(ss2), .clr(clr2), .load(load2),
        .load_val(load_val2), .dir(dir2), .dig(dig2), .running(running2),
        .tick(tick2), .wrap(wrap2), .done(done2)
    );

    function automatic logic [W-1:0] pack(input logic [31:0] c, input logic [5:0] d,
                                          input logic t, input logic w,
                                          input logic dn, input logic r);
        return {c, d, t, w, dn, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: every pulse cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (tick || wrap || done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got %0h expected none",
                         pack(cyc, dig, tick, wrap, done, running));
            end else begin
                check("pulse", 64'(pack(cyc, dig, tick, wrap, done, running)),
                      64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic pulse_load(input logic [5:0] v);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        int unsigned p;
        int unsigned p2;
        nrst = 1'b0; start_stop = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0; load_val = '0;
        nrst2 = 1'b0; ss2 = 1'b0; clr2 = 1'b0; load2 = 1'b0; dir2 = 1'b0; load_val2 = '0;
        repeat (3) @(negedge clk);

        check("rst_dig", 64'(dig), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        check("rst_tick", 64'(tick), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        nrst = 1'b1;
        nrst2 = 1'b1;
        step_n(1);

        // Up count from 0: steps every TD cycles after the start pulse.
        dir = 1'b0;
        p = cyc + 1;
        for (int k = 1; k <= 3; k++)
            exp_q.push_back(pack(32'(p + TD * k), 6'(k), 1'b1, 1'b0, 1'b0, 1'b1));
        pulse_start();
        check("s1_running", 64'(running), 64'd1);
        step_n(12);
        check("s1_dig", 64'(dig), 64'd3);
        pulse_clr();
        check("clr_dig", 64'(dig), 64'd0);
        check("clr_running", 64'(running), 64'd0);

        // Wrap 59 -> 0 keeps running.
        pulse_load(6'd58);
        check("load58", 64'(dig), 64'd58);
        p = cyc + 1;
        exp_q.push_back(pack(p + 4,  6'd59, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(pack(p + 8,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(pack(p + 12, 6'd1,  1'b1, 1'b0, 1'b0, 1'b1));
        pulse_start();
        step_n(12);
        check("wrap_running", 64'(running), 64'd1);
        pulse_clr();

        // Countdown 2,1,0 then DONE ignores start_stop.
        dir = 1'b1;
        pulse_load(6'd2);
        p = cyc + 1;
        exp_q.push_back(pack(p + 4, 6'd1, 1'b1, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(pack(p + 8, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0));
        pulse_start();
        step_n(8);
        check("down_dig", 64'(dig), 64'd0);
        check("down_running", 64'(running), 64'd0);
        pulse_start();
        step_n(5);
        pulse_start();
        step_n(5);
        check("done_dig", 64'(dig), 64'd0);
        check("done_running", 64'(running), 64'd0);
        check("done_state", 64'(u_dut.state), 64'(ST_DONE));
        pulse_clr();
        dir = 1'b0;

        // Pause with prescaler at 2, resume restarts the prescaler.
        pulse_load(6'd4);
        p = cyc + 1;
        exp_q.push_back(pack(p + 4, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1));
        pulse_start();
        step_n(6);
        check("psc_at_2", 64'(u_dut.u_tick.cnt), 64'd2);
        pulse_start();
        step_n(20);
        check("pause_running", 64'(running), 64'd0);
        check("pause_dig", 64'(dig), 64'd5);
        p = cyc + 1;
        exp_q.push_back(pack(p + 4, 6'd6, 1'b1, 1'b0, 1'b0, 1'b1));
        pulse_start();
        step_n(4);
        check("resume_dig", 64'(dig), 64'd6);
        pulse_clr();

        // clr beats load beats start_stop.
        pulse_load(6'd9);
        clr = 1'b1; load = 1'b1; load_val = 6'd30; start_stop = 1'b1;
        @(negedge clk);
        clr = 1'b0; load = 1'b0; start_stop = 1'b0;
        step_n(10);
        check("prio_dig", 64'(dig), 64'd0);
        check("prio_running", 64'(running), 64'd0);
        check("prio_state", 64'(u_dut.state), 64'(ST_IDLE));

        // Countdown start at 0 goes straight to DONE.
        dir = 1'b1;
        p = cyc + 1;
        exp_q.push_back(pack(p, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        pulse_start();
        step_n(2);
        check("zero_down_running", 64'(running), 64'd0);
        pulse_clr();
        dir = 1'b0;

        pulse_load(6'd63);
        check("clamp", 64'(dig), 64'd59);
        pulse_clr();

        // Mid-run reset at dig=17.
        pulse_load(6'd16);
        p = cyc + 1;
        exp_q.push_back(pack(p + 4, 6'd17, 1'b1, 1'b0, 1'b0, 1'b1));
        pulse_start();
        step_n(4);
        check("pre_rst_dig", 64'(dig), 64'd17);
        nrst = 1'b0;
        @(negedge clk);
        check("mrst_dig", 64'(dig), 64'd0);
        check("mrst_running", 64'(running), 64'd0);
        check("mrst_pulses", 64'({tick, wrap, done}), 64'd0);
        nrst = 1'b1;

        // Minimum divider instance.
        p2 = cyc + 1;
        ss2 = 1'b1;
        @(negedge clk);
        ss2 = 1'b0;
        step_n(2);
        check("div2_cycle", 64'(cyc - p2), 64'd2);
        check("div2_dig1", 64'(dig2), 64'd1);
        check("div2_tick1", 64'(tick2), 64'd1);
        step_n(1);
        check("div2_gap_tick", 64'(tick2), 64'd0);
        step_n(1);
        check("div2_dig2", 64'(dig2), 64'd2);
        check("div2_tick2", 64'(tick2), 64'd1);
        check("div2_running", 64'(running2), 64'd1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
